// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-add multiplier datapath: LOAD, then WIDTH ADD/SHIFT pairs, then DONE until ack.
// Optional abort input when MULT_SEQ_ABORT_EN is defined.
//
// state | meaning
// IDLE  | ready for start
// LOAD  | load Areg/Breg, clear Preg
// ADD   | conditional Preg += Breg on a_lsb
// SHIFT | shift {carry,Preg,Areg} right, advance iteration
// DONE  | result valid, wait for ack
module mult_seq_ctrl #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_lsb,
    input  logic             ack,
`ifdef MULT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             ready,
    output logic             ld_ab,
    output logic             clr_p,
    output logic             ld_p,
    output logic             sh,
    output logic             done,
    output logic [4:0]       ps,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_LOAD  = 5'b00010,
        S_ADD   = 5'b00100,
        S_SHIFT = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

    state_t           ps_q, ps_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [4:0]       ps_bits;

    always_comb begin
        ps_d   = S_IDLE;
        iter_d = iter_q;
        case (ps_q)
            S_IDLE:  ps_d = start ? S_LOAD : S_IDLE;
            S_LOAD: begin
                ps_d   = S_ADD;
                iter_d = '0;
            end
            S_ADD:   ps_d = S_SHIFT;
            S_SHIFT: begin
                if (iter_q == ITER_LAST) begin
                    ps_d   = S_DONE;
                    iter_d = '0;
                end else begin
                    ps_d   = S_ADD;
                    iter_d = iter_q + CNT_W'(1);
                end
            end
            S_DONE:  ps_d = ack ? S_IDLE : S_DONE;
            default: begin
                ps_d   = S_IDLE;
                iter_d = '0;
            end
        endcase
`ifdef MULT_SEQ_ABORT_EN
        // abort wins over every busy-state transition, including SHIFT->DONE
        if (abort && (ps_q == S_LOAD || ps_q == S_ADD || ps_q == S_SHIFT)) begin
            ps_d   = S_IDLE;
            iter_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q   <= S_IDLE;
            iter_q <= '0;
        end else begin
            ps_q   <= ps_d;
            iter_q <= iter_d;
        end
    end

    assign ps_bits = ps_q;
    assign ps      = ps_bits;
    assign iter    = iter_q;
    assign ready   = ps_bits[0];
    assign ld_ab   = ps_bits[1];
    assign clr_p   = ps_bits[1];
    assign ld_p    = ps_bits[2] & a_lsb;
    assign sh      = ps_bits[3];
    assign done    = ps_bits[4];

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomized bench for mult_seq_ctrl with a small shift-add datapath model; products checked against A*B.
// Exercises the abort path when MULT_SEQ_ABORT_EN is defined.
module tb_mult_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       ack = 1'b0;
    logic       a_lsb;
`ifdef MULT_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       ready, ld_ab, clr_p, ld_p, sh, done;
    logic [4:0] ps;
    logic [1:0] iter;

    logic [3:0] a_bus = '0, b_bus = '0;
    logic [3:0] areg = '0, breg = '0, preg = '0;
    logic       carry = 1'b0;
    logic [7:0] result;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [4:0] P_IDLE  = 5'b00001;
    localparam logic [4:0] P_LOAD  = 5'b00010;
    localparam logic [4:0] P_ADD   = 5'b00100;
    localparam logic [4:0] P_SHIFT = 5'b01000;
    localparam logic [4:0] P_DONE  = 5'b10000;

    mult_seq_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_lsb (a_lsb),
        .ack   (ack),
`ifdef MULT_SEQ_ABORT_EN
        .abort (abort),
`endif
        .ready (ready),
        .ld_ab (ld_ab),
        .clr_p (clr_p),
        .ld_p  (ld_p),
        .sh    (sh),
        .done  (done),
        .ps    (ps),
        .iter  (iter)
    );

    always #5 clk = ~clk;

    // Datapath model driven by the controller's strobes
    assign a_lsb  = areg[0];
    assign result = {preg, areg};
    always @(posedge clk) begin
        if (ld_ab) begin
            areg <= a_bus;
            breg <= b_bus;
        end
        if (clr_p) begin
            preg  <= '0;
            carry <= 1'b0;
        end else if (ld_p) begin
            {carry, preg} <= {1'b0, preg} + {1'b0, breg};
        end else if (sh) begin
            {carry, preg, areg} <= {1'b0, carry, preg, areg[3:1]};
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One multiply from IDLE; returns in IDLE (or after abort)
    task automatic do_mult(input logic [3:0] a, input logic [3:0] b, input int ack_wait,
                           input bit stray, input bit start_with_ack, input int abort_at);
        logic [7:0] exp_prod;
        exp_prod = {4'b0, a} * {4'b0, b};
        check_val("ready_idle", 32'(ready), 32'd1);
        a_bus = a;
        b_bus = b;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("ps_load", 32'(ps), 32'(P_LOAD));
        check_val("load_strb", 32'({ld_ab, clr_p, ready, done}), 32'b1100);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("ps_add", 32'(ps), 32'(P_ADD));
            check_val("ld_p_iter", 32'({ld_p, sh}), 32'({a[i], 1'b0}));
            if (stray) begin
                start = 1'b1;
                ack   = 1'b1;
            end
            step();
            start = 1'b0;
            ack   = 1'b0;
            check_val("ps_shift", 32'(ps), 32'(P_SHIFT));
            check_val("shift_strb", 32'({sh, ld_p, ld_ab, ready}), 32'b1000);
            check_val("iter", 32'(iter), 32'(i));
`ifdef MULT_SEQ_ABORT_EN
            if (i == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                check_val("abort_idle", 32'(ps), 32'(P_IDLE));
                check_val("abort_iter", 32'(iter), 32'd0);
                step();
                check_val("abort_nodone", 32'(done), 32'd0);
                return;
            end
`endif
            if (stray) start = 1'b1;
        end
        step();
        start = 1'b0;
        check_val("done_lat", 32'(done), 32'd1);
        check_val("ps_done", 32'(ps), 32'(P_DONE));
        check_val("result", 32'(result), 32'(exp_prod));
        for (int k = 0; k < ack_wait; k++) begin
            step();
            check_val("done_hold", 32'(done), 32'd1);
        end
        ack = 1'b1;
        if (start_with_ack) start = 1'b1;
        step();
        ack   = 1'b0;
        start = 1'b0;
        check_val("ps_after_ack", 32'(ps), 32'(P_IDLE));
        check_val("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int last_done, n_done, bad_width, bad_gap, bad_res, bad_ready;
        logic prev_done;

        step();
        check_val("rst_ps", 32'(ps), 32'(P_IDLE));
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            check_val("idle_ps", 32'(ps), 32'(P_IDLE));
            check_val("idle_strb", 32'({ld_ab, clr_p, ld_p, sh, done, ready}), 32'b000001);
            check_val("idle_iter", 32'(iter), 32'd0);
        end

        do_mult(4'b1011, 4'b0110, 0, 1'b0, 1'b0, -1);
        check_val("basic_42", 32'(result), 32'h42);
        do_mult(4'h0, 4'hF, 5, 1'b0, 1'b0, -1);
        check_val("zero_res", 32'(result), 32'h00);
        do_mult(4'h7, 4'h9, 2, 1'b1, 1'b1, -1);
        for (int n = 0; n < 12; n++) begin
            do_mult(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        // back-to-back with start and ack held high
        a_bus = 4'd9;
        b_bus = 4'd7;
        start = 1'b1;
        ack   = 1'b1;
        last_done = -1;
        n_done = 0;
        bad_width = 0;
        bad_gap = 0;
        bad_res = 0;
        bad_ready = 0;
        prev_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (done) begin
                if (prev_done) bad_width++;
                if (last_done >= 0 && c - last_done != 11) bad_gap++;
                if (result !== 8'd63) bad_res++;
                last_done = c;
                n_done++;
            end
            if (ready && ps !== P_IDLE) bad_ready++;
            if (!ready && ps === P_IDLE) bad_ready++;
            prev_done = done;
        end
        start = 1'b0;
        check_val("b2b_count", 32'(n_done >= 5), 32'd1);
        check_val("b2b_width", 32'(bad_width), 32'd0);
        check_val("b2b_gap", 32'(bad_gap), 32'd0);
        check_val("b2b_result", 32'(bad_res), 32'd0);
        check_val("b2b_ready", 32'(bad_ready), 32'd0);
        for (int c = 0; c < 20 && ps !== P_IDLE; c++) step();
        ack = 1'b0;
        check_val("drain_idle", 32'(ps), 32'(P_IDLE));

        // asynchronous reset in the middle of SHIFT
        a_bus = 4'd5;
        b_bus = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_val("pre_rst_shift", 32'(ps), 32'(P_SHIFT));
        #2 rst = 1'b0;
        #1;
        check_val("async_rst_ps", 32'(ps), 32'(P_IDLE));
        check_val("async_rst_strb", 32'({ld_ab, clr_p, ld_p, sh, done, ready}), 32'b000001);
        check_val("async_rst_iter", 32'(iter), 32'd0);
        step();
        #2 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("post_rst", 32'({ps, ld_ab, clr_p, ld_p, sh, done}), 32'({P_IDLE, 5'b00000}));
        end
        do_mult(4'hD, 4'hB, 0, 1'b0, 1'b0, -1);

`ifdef MULT_SEQ_ABORT_EN
        do_mult(4'hF, 4'hF, 0, 1'b0, 1'b0, 2);
        do_mult(4'hF, 4'hF, 0, 1'b0, 1'b0, -1);
        check_val("after_abort_e1", 32'(result), 32'hE1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
